uart_delay_cmd_sequencer: RTL and testbench

- Command-frame controller between the UART receiver and the delay-channel register bank.
- Consumes received bytes, frames and validates 5-byte commands, then issues one-cycle write strobes to per-channel delay registers or a global commit strobe.
- Handles inter-byte timeout and framing errors so a corrupted or partial stream never reaches the delay bank.

---
 rtl/uart_delay_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_uart_delay_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_delay_cmd_sequencer.sv
// Frames 5-byte UART commands (A5 CMD DLO DHI CHK) and turns them into delay-bank
// register writes, commit strobes or frame-error strobes.
module uart_delay_cmd_sequencer #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int CHANNELS        = 8,
   parameter int DELAY_WIDTH     = 16,
   parameter int TIMEOUT_BYTES   = 4
) (
   input  logic                   clockIN,
   input  logic                   nRxResetIN,
   input  logic                   rxReadyIN,
   input  logic                   rxIdleIN,
   input  logic [7:0]             rxDataIN,
   output logic                   cfgWrOUT,
   output logic [3:0]             cfgChanOUT,
   output logic [DELAY_WIDTH-1:0] cfgDataOUT,
   output logic                   commitOUT,
   output logic                   frameErrOUT,
   output logic                   busyOUT
);

   localparam longint BYTE_CYCLES    = (longint'(CLOCK_FREQUENCY) * 10) / longint'(BAUD_RATE);
   localparam longint TIMEOUT_CYCLES = longint'(TIMEOUT_BYTES) * BYTE_CYCLES;
   localparam int     CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]       CHAN_LIMIT = 5'(CHANNELS);
   localparam logic [7:0]       SYNC_BYTE  = 8'hA5;
   localparam logic [3:0]       OP_WRITE   = 4'h1;
   localparam logic [3:0]       OP_COMMIT  = 4'h2;

   typedef enum logic [2:0] {HUNT, CMD, DLO, DHI, CHK, EXEC} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [7:0]       cmd_q, dlo_q, dhi_q, chk_q;
   logic             wr_next, commit_next, err_next;
   logic             rdy_meta, rdy_s, rdy_s_d;
   logic             idle_meta, idle_s;
   logic             byte_stb;
   logic             unused_idle;

   // Receiver levels cross into clockIN here; a byte is announced by the ready rising edge.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         rdy_meta  <= 1'b0;
         rdy_s     <= 1'b0;
         rdy_s_d   <= 1'b0;
         idle_meta <= 1'b0;
         idle_s    <= 1'b0;
      end else begin
         rdy_meta  <= rxReadyIN;
         rdy_s     <= rdy_meta;
         rdy_s_d   <= rdy_s;
         idle_meta <= rxIdleIN;
         idle_s    <= idle_meta;
      end
   end

   assign byte_stb    = rdy_s & ~rdy_s_d;
   assign unused_idle = idle_s;
   assign busyOUT     = (state != HUNT);

   // Frame sequencing, inter-byte timeout and the execute decision on the checksum byte.
   always_comb begin
      state_next  = state;
      cnt_next    = '0;
      wr_next     = 1'b0;
      commit_next = 1'b0;
      err_next    = 1'b0;
      case (state)
         HUNT: begin
            if (byte_stb && rxDataIN == SYNC_BYTE) state_next = CMD;
         end
         CMD, DLO, DHI, CHK: begin
            if (byte_stb) begin
               case (state)
                  CMD:     state_next = DLO;
                  DLO:     state_next = DHI;
                  DHI:     state_next = CHK;
                  default: begin
                     state_next = EXEC;
                     if (rxDataIN != chk_q)
                        err_next = 1'b1;
                     else if (cmd_q[7:4] == OP_WRITE && {1'b0, cmd_q[3:0]} < CHAN_LIMIT)
                        wr_next = 1'b1;
                     else if (cmd_q[7:4] == OP_COMMIT)
                        commit_next = 1'b1;
                     else
                        err_next = 1'b1;
                  end
               endcase
            end else if (cnt == CNT_LAST) begin
               state_next = HUNT;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         EXEC:    state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   // State, captured frame bytes, running checksum and registered strobes.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         state       <= HUNT;
         cnt         <= '0;
         cmd_q       <= '0;
         dlo_q       <= '0;
         dhi_q       <= '0;
         chk_q       <= '0;
         cfgWrOUT    <= 1'b0;
         commitOUT   <= 1'b0;
         frameErrOUT <= 1'b0;
         cfgChanOUT  <= '0;
         cfgDataOUT  <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         cfgWrOUT    <= wr_next;
         commitOUT   <= commit_next;
         frameErrOUT <= err_next;
         if (byte_stb) begin
            case (state)
               CMD: begin
                  cmd_q <= rxDataIN;
                  chk_q <= rxDataIN;
               end
               DLO: begin
                  dlo_q <= rxDataIN;
                  chk_q <= chk_q ^ rxDataIN;
               end
               DHI: begin
                  dhi_q <= rxDataIN;
                  chk_q <= chk_q ^ rxDataIN;
               end
               default: ;
            endcase
         end
         if (wr_next) begin
            cfgChanOUT <= cmd_q[3:0];
            cfgDataOUT <= DELAY_WIDTH'({dhi_q, dlo_q});
         end
      end
   end

endmodule

// File: tb/tb_uart_delay_cmd_sequencer.sv
// Scoreboard bench for uart_delay_cmd_sequencer: a byte-level frame model predicts
// each strobe and its cycle; a monitor pops and compares whenever a strobe appears.
module tb_uart_delay_cmd_sequencer;

   localparam int CF        = 1_000_000;
   localparam int BR        = 20_000;
   localparam int CH        = 8;
   localparam int TO_BYTES  = 4;
   localparam int LIMIT     = TO_BYTES * 10 * CF / BR;

   logic        clockIN    = 1'b0;
   logic        nRxResetIN = 1'b0;
   logic        rxReadyIN  = 1'b0;
   logic        rxIdleIN   = 1'b1;
   logic [7:0]  rxDataIN   = 8'h00;
   logic        cfgWrOUT;
   logic [3:0]  cfgChanOUT;
   logic [15:0] cfgDataOUT;
   logic        commitOUT;
   logic        frameErrOUT;
   logic        busyOUT;

   uart_delay_cmd_sequencer #(
      .CLOCK_FREQUENCY(CF),
      .BAUD_RATE(BR),
      .CHANNELS(CH),
      .DELAY_WIDTH(16),
      .TIMEOUT_BYTES(TO_BYTES)
   ) dut (
      .clockIN(clockIN),
      .nRxResetIN(nRxResetIN),
      .rxReadyIN(rxReadyIN),
      .rxIdleIN(rxIdleIN),
      .rxDataIN(rxDataIN),
      .cfgWrOUT(cfgWrOUT),
      .cfgChanOUT(cfgChanOUT),
      .cfgDataOUT(cfgDataOUT),
      .commitOUT(commitOUT),
      .frameErrOUT(frameErrOUT),
      .busyOUT(busyOUT)
   );

   always #5 clockIN = ~clockIN;

   int cyc = 0;
   always @(posedge clockIN) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  strobes;
      logic [3:0]  chan;
      logic [15:0] data;
      int          at;
      logic        busy;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] frame[$];
   int         last_raise = 0;
   logic [3:0] last_chan  = 4'h0;
   logic [15:0] last_data = 16'h0000;
   int         checks = 0;
   int         fails  = 0;
   logic       busy_pending = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Outcome of one complete frame, decided from the frame rules alone.
   function automatic void evalFrame(input int at);
      exp_t e;
      logic [7:0] cmd;
      cmd = frame[1];
      e.at   = at;
      e.busy = 1'b1;
      if (frame[4] != (frame[1] ^ frame[2] ^ frame[3]))
         e.strobes = 3'b001;
      else if (cmd[7:4] == 4'h1 && int'(cmd[3:0]) < CH) begin
         e.strobes = 3'b100;
         last_chan = cmd[3:0];
         last_data = {frame[3], frame[2]};
      end else if (cmd[7:4] == 4'h2)
         e.strobes = 3'b010;
      else
         e.strobes = 3'b001;
      e.chan = last_chan;
      e.data = last_data;
      sb.push_back(e);
   endfunction

   // One received byte: ready rises at a falling edge; its effect shows 3 cycles later.
   task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
      int n;
      n = cyc;
      rxDataIN  = b;
      rxReadyIN = 1'b1;
      rxIdleIN  = 1'b0;
      if (frame.size() == 0) begin
         if (b == 8'hA5) frame.push_back(b);
      end else begin
         frame.push_back(b);
         if (frame.size() == 5) begin
            evalFrame(n + 3);
            frame.delete();
         end
      end
      last_raise = n;
      repeat (hold) @(negedge clockIN);
      rxReadyIN = 1'b0;
      rxIdleIN  = 1'b1;
      repeat (gap) @(negedge clockIN);
   endtask

   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] dlo, input logic [7:0] dhi,
                            input logic [7:0] flip, input int hold, input int gap);
      applyStimulus(8'hA5, hold, gap);
      applyStimulus(cmd, hold, gap);
      applyStimulus(dlo, hold, gap);
      applyStimulus(dhi, hold, gap);
      applyStimulus(cmd ^ dlo ^ dhi ^ flip, hold, gap);
   endtask

   // Silence on the line; a partial frame that outlives the gap limit is predicted to time out.
   task automatic idleCycles(input int k);
      exp_t e;
      if (frame.size() != 0 && cyc + k > last_raise + LIMIT) begin
         e.strobes = 3'b001;
         e.chan    = last_chan;
         e.data    = last_data;
         e.at      = last_raise + LIMIT + 3;
         e.busy    = 1'b0;
         sb.push_back(e);
         frame.delete();
      end
      repeat (k) @(negedge clockIN);
   endtask

   task automatic resetDut();
      nRxResetIN = 1'b0;
      frame.delete();
      last_chan = 4'h0;
      last_data = 16'h0000;
      #1;
      checkOutput("reset_wr", cfgWrOUT, 0);
      checkOutput("reset_commit", commitOUT, 0);
      checkOutput("reset_err", frameErrOUT, 0);
      checkOutput("reset_busy", busyOUT, 0);
      checkOutput("reset_chan", cfgChanOUT, 0);
      checkOutput("reset_data", cfgDataOUT, 0);
      repeat (3) @(negedge clockIN);
      nRxResetIN = 1'b1;
      repeat (2) @(negedge clockIN);
   endtask

   // Monitor: every strobe must match the head of the scoreboard, then HUNT must follow.
   initial begin
      exp_t e;
      forever begin
         @(negedge clockIN);
         if (!nRxResetIN) begin
            busy_pending = 1'b0;
         end else begin
            if (busy_pending) begin
               checkOutput("busy_after_strobe", busyOUT, 0);
               busy_pending = 1'b0;
            end
            if (cfgWrOUT || commitOUT || frameErrOUT) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL unexpected_strobe: got wr/commit/err=%b, expected none (cycle %0d)",
                           {cfgWrOUT, commitOUT, frameErrOUT}, cyc);
               end else begin
                  e = sb.pop_front();
                  checkOutput("strobe_kind", {29'd0, cfgWrOUT, commitOUT, frameErrOUT}, {29'd0, e.strobes});
                  checkOutput("strobe_cycle", cyc, e.at);
                  checkOutput("cfg_chan", cfgChanOUT, e.chan);
                  checkOutput("cfg_data", cfgDataOUT, e.data);
                  checkOutput("busy_at_strobe", busyOUT, e.busy);
                  busy_pending = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int target;
      repeat (3) @(negedge clockIN);
      resetDut();

      $display("[TB] basic write, commit, back-to-back");
      sendFrame(8'h13, 8'h34, 8'h12, 8'h00, 2, 3);
      sendFrame(8'h20, 8'h00, 8'h00, 8'h00, 1, 2);
      sendFrame(8'h10, 8'hFF, 8'hFF, 8'h00, 1, 2);

      $display("[TB] rejected frames");
      sendFrame(8'h13, 8'h34, 8'h12, 8'h35, 2, 3);
      sendFrame(8'h19, 8'h00, 8'h00, 8'h00, 2, 3);
      sendFrame(8'h30, 8'h11, 8'h22, 8'h00, 2, 3);

      $display("[TB] noise and held ready");
      applyStimulus(8'h00, 2, 3);
      applyStimulus(8'hFF, 2, 3);
      applyStimulus(8'h5A, 2, 3);
      sendFrame(8'h13, 8'h34, 8'h12, 8'h00, 2, 3);
      applyStimulus(8'hA5, 2, 3);
      applyStimulus(8'h15, 1000, 3);
      applyStimulus(8'hCD, 2, 3);
      applyStimulus(8'hAB, 2, 3);
      applyStimulus(8'h15 ^ 8'hCD ^ 8'hAB, 2, 3);

      $display("[TB] timeout");
      applyStimulus(8'hA5, 2, 3);
      applyStimulus(8'h13, 2, 3);
      idleCycles(LIMIT + 50);
      sendFrame(8'h17, 8'h78, 8'h56, 8'h00, 2, 3);

      applyStimulus(8'hA5, 2, 3);
      applyStimulus(8'h12, 2, 3);
      target = last_raise + LIMIT;
      idleCycles(target - cyc);
      applyStimulus(8'h34, 2, 3);
      applyStimulus(8'h12, 2, 3);
      applyStimulus(8'h12 ^ 8'h34 ^ 8'h12, 2, 3);

      applyStimulus(8'hA5, 2, 3);
      applyStimulus(8'h13, 2, 3);
      target = last_raise + LIMIT + 1;
      idleCycles(target - cyc);
      applyStimulus(8'h34, 2, 3);
      applyStimulus(8'h12, 2, 3);
      applyStimulus(8'h35, 2, 3);
      idleCycles(10);

      $display("[TB] reset mid-frame");
      applyStimulus(8'hA5, 2, 3);
      applyStimulus(8'h13, 2, 3);
      applyStimulus(8'h34, 2, 3);
      resetDut();
      applyStimulus(8'h12, 2, 3);
      applyStimulus(8'h35, 2, 3);
      sendFrame(8'h20, 8'h01, 8'h02, 8'h00, 2, 3);

      $display("[TB] randomized frames");
      for (int i = 0; i < 40; i++) begin
         int nnoise, r, hold, gap;
         logic [7:0] nb, cmd, flip;
         logic [3:0] op;
         hold   = $urandom_range(1, 4);
         gap    = $urandom_range(2, 4);
         nnoise = $urandom_range(0, 2);
         for (int j = 0; j < nnoise; j++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == 8'hA5) nb = 8'h00;
            applyStimulus(nb, hold, gap);
         end
         r = $urandom_range(0, 9);
         if (r < 5)      op = 4'h1;
         else if (r < 8) op = 4'h2;
         else            op = 4'($urandom_range(0, 15));
         cmd  = {op, 4'($urandom_range(0, 15))};
         flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         sendFrame(cmd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), flip, hold, gap);
      end

      idleCycles(20);
      checkOutput("scoreboard_drained", sb.size(), 0);
      checkOutput("final_busy", busyOUT, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
